// File: rtl/matrix_result_serializer.sv
// matrix_result_serializer
// Snapshots a packed matrix result word and streams it out one byte at a
// time, most significant byte first, optionally followed by an XOR checksum
// byte. A capture request that arrives while a frame is in flight is dropped
// and recorded in a sticky overrun flag.
module matrix_result_serializer #(
    parameter int DATA_WIDTH   = 64,
    parameter int BYTE_WIDTH   = 8,
    parameter int ADD_CHECKSUM = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] result_in,
    output logic [BYTE_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  overrun
);

    localparam int NDATA = DATA_WIDTH / BYTE_WIDTH;
    localparam int NB    = NDATA + ((ADD_CHECKSUM != 0) ? 1 : 0);
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [BYTE_WIDTH-1:0] csum_q,  csum_d;
    logic                  ovr_q,   ovr_d;

    logic                  sending;
    logic                  at_last;
    logic                  is_data;
    logic [BYTE_WIDTH-1:0] data_byte;

    // The checksum, when present, is always the final byte of the frame, so
    // every index other than the last one selects a data byte.
    assign sending   = (state_q == SEND);
    assign at_last   = (idx_q == LAST_IDX);
    assign is_data   = (ADD_CHECKSUM == 0) || !at_last;
    assign data_byte = shift_q[DATA_WIDTH-1 -: BYTE_WIDTH];

    // Outputs are decoded purely from registered state; out_ready and capture
    // never reach an output combinationally.
    assign out_data  = is_data ? data_byte : csum_q;
    assign out_valid = sending;
    assign out_last  = sending && at_last;
    assign busy      = sending;
    assign overrun   = ovr_q;

    // Next-state logic: clear beats capture and transfer; capture while
    // sending is dropped but latched as an overrun.
    always_comb begin : next_state
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        ovr_d   = ovr_q;

        if (clear) begin
            state_d = IDLE;
            idx_d   = '0;
            csum_d  = '0;
            ovr_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        shift_d = result_in;
                        idx_d   = '0;
                        csum_d  = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (capture) begin
                        ovr_d = 1'b1;
                    end
                    if (out_ready) begin
                        if (is_data) begin
                            shift_d = shift_q << BYTE_WIDTH;
                            csum_d  = csum_q ^ data_byte;
                        end
                        if (at_last) begin
                            // Park the index at zero so it is ready for the next frame.
                            idx_d   = '0;
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q + IDX_ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin : state_reg
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Scoreboard bench for matrix_result_serializer: one instance with the
// checksum byte enabled, one without. Expected bytes are queued when a
// capture is issued; a monitor thread pops and compares on each transfer.
module tb_matrix_result_serializer;

    logic        clock;
    logic        reset;

    logic        clear0, capture0, ready0;
    logic [63:0] res0;
    logic [7:0]  out_data0;
    logic        out_valid0, out_last0, busy0, overrun0;

    logic        clear1, capture1, ready1;
    logic [63:0] res1;
    logic [7:0]  out_data1;
    logic        out_valid1, out_last1, busy1, overrun1;

    int          n_cmp = 0;
    int          n_err = 0;
    int          pops0 = 0;
    int          pops1 = 0;
    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic        bp = 1'b0;

    matrix_result_serializer #(
        .DATA_WIDTH(64), .BYTE_WIDTH(8), .ADD_CHECKSUM(1)
    ) dut0 (
        .clock(clock), .reset(reset), .clear(clear0), .capture(capture0),
        .result_in(res0), .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(ready0), .out_last(out_last0), .busy(busy0), .overrun(overrun0)
    );

    matrix_result_serializer #(
        .DATA_WIDTH(64), .BYTE_WIDTH(8), .ADD_CHECKSUM(0)
    ) dut1 (
        .clock(clock), .reset(reset), .clear(clear1), .capture(capture1),
        .result_in(res1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(ready1), .out_last(out_last1), .busy(busy1), .overrun(overrun1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    // Queue one frame: data bytes MSB first, then the checksum byte if enabled.
    task automatic push_frame(input int which, input logic [63:0] w, input logic [7:0] ck);
        for (int i = 0; i < 8; i++) begin
            if (which == 0) q0.push_back({1'b0, w[63 - 8*i -: 8]});
            else            q1.push_back({(i == 7), w[63 - 8*i -: 8]});
        end
        if (which == 0) q0.push_back({1'b1, ck});
    endtask

    task automatic do_capture0(input logic [63:0] w, input logic [7:0] ck);
        push_frame(0, w, ck);
        res0     = w;
        capture0 = 1'b1;
        cyc();
        capture0 = 1'b0;
        res0     = ~w;   // later changes must not leak into the frame
    endtask

    task automatic wait_idle0(input int bound);
        int n = 0;
        while (busy0 && n < bound) begin
            cyc();
            n++;
        end
        check("idle0_timeout", (n < bound), 1);
    endtask

    task automatic wait_pops0(input int target, input int bound);
        int n = 0;
        while (pops0 < target && n < bound) begin
            cyc();
            n++;
        end
        check("pops0_timeout", (n < bound), 1);
    endtask

    initial begin
        int         base;
        int         n;
        logic [15:0] pat;
        pat      = 16'b1001_1010_0110_0111;
        reset    = 1'b0;
        clear0   = 1'b0; capture0 = 1'b0; ready0 = 1'b1; res0 = '0;
        clear1   = 1'b0; capture1 = 1'b0; ready1 = 1'b1; res1 = '0;

        fork
            // Ready driver for dut0: constant 1 or a fixed toggling pattern.
            begin
                int k = 0;
                forever begin
                    @(posedge clock);
                    #2;
                    ready0 = bp ? pat[k % 16] : 1'b1;
                    k++;
                end
            end
            // Monitor: pops and compares on every transfer, and checks
            // that stalled outputs stay frozen.
            begin
                logic       stall0 = 1'b0;
                logic [8:0] prev0 = '0;
                logic [8:0] e;
                forever begin
                    @(negedge clock);
                    if (!reset) begin
                        stall0 = 1'b0;
                    end else begin
                        if (stall0) begin
                            check("stall_valid0", out_valid0, 1);
                            check("stall_hold0", {out_last0, out_data0}, prev0);
                        end
                        if (!clear0 && out_valid0 && ready0) begin
                            check("frame_len0", (q0.size() != 0), 1);
                            if (q0.size() != 0) begin
                                e = q0.pop_front();
                                check("byte0", {out_last0, out_data0}, e);
                                pops0++;
                            end
                        end
                        stall0 = !clear0 && out_valid0 && !ready0;
                        prev0  = {out_last0, out_data0};
                        if (!clear1 && out_valid1 && ready1) begin
                            check("frame_len1", (q1.size() != 0), 1);
                            if (q1.size() != 0) begin
                                e = q1.pop_front();
                                check("byte1", {out_last1, out_data1}, e);
                                pops1++;
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) cyc();
        check("rst_data0", out_data0, 0);
        check("rst_valid0", out_valid0, 0);
        check("rst_last0", out_last0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_ovr0", overrun0, 0);
        check("rst_valid1", out_valid1, 0);
        reset = 1'b1;
        repeat (2) cyc();

        // Basic frame: checksum of 01..08 is 08; busy for exactly 9 cycles
        do_capture0(64'h0102030405060708, 8'h08);
        check("first_byte_latency", {out_valid0, out_data0}, {1'b1, 8'h01});
        n = 0;
        while (busy0 && n < 50) begin
            n++;
            cyc();
        end
        check("busy_cycles0", n, 9);
        check("ovr_after_basic", overrun0, 0);
        check("q0_empty_basic", q0.size(), 0);

        // Back-pressure
        bp = 1'b1;
        do_capture0(64'h0102030405060708, 8'h08);
        wait_idle0(200);
        bp = 1'b0;
        cyc();
        check("q0_empty_bp", q0.size(), 0);

        // Overrun during byte 3 and on the final-transfer cycle
        base = pops0;
        do_capture0(64'h0102030405060708, 8'h08);
        wait_pops0(base + 3, 100);
        res0 = 64'hFFFF_FFFF_FFFF_FFFF;
        capture0 = 1'b1;
        cyc();
        capture0 = 1'b0;
        check("ovr_set_mid", overrun0, 1);
        n = 0;
        while (!(out_valid0 && out_last0) && n < 50) begin
            cyc();
            n++;
        end
        check("last_timeout", (n < 50), 1);
        capture0 = 1'b1;
        cyc();
        capture0 = 1'b0;
        repeat (12) cyc();
        check("no_ff_frame_busy", busy0, 0);
        check("ovr_sticky", overrun0, 1);
        check("q0_empty_ovr", q0.size(), 0);
        clear0 = 1'b1;
        cyc();
        clear0 = 1'b0;
        check("ovr_cleared", overrun0, 0);

        // Clear after byte 4, then a new frame; the paired bytes cancel so the checksum is 00
        base = pops0;
        do_capture0(64'h0102030405060708, 8'h08);
        wait_pops0(base + 4, 100);
        clear0 = 1'b1;
        q0.delete();
        cyc();
        clear0 = 1'b0;
        check("clear_valid0", out_valid0, 0);
        check("clear_busy0", busy0, 0);
        do_capture0(64'hA5A5_0000_0000_5A5A, 8'h00);
        wait_idle0(100);
        cyc();
        check("q0_empty_clear", q0.size(), 0);

        // Asynchronous reset during byte 2, with overrun set beforehand
        base = pops0;
        do_capture0(64'h0102030405060708, 8'h08);
        capture0 = 1'b1;
        cyc();
        capture0 = 1'b0;
        wait_pops0(base + 2, 100);
        check("ovr_before_rst", overrun0, 1);
        #1;
        reset = 1'b0;
        #1;
        check("arst_data0", out_data0, 0);
        check("arst_valid0", out_valid0, 0);
        check("arst_last0", out_last0, 0);
        check("arst_busy0", busy0, 0);
        check("arst_ovr0", overrun0, 0);
        q0.delete();
        cyc();
        reset = 1'b1;
        cyc();
        do_capture0(64'h0102030405060708, 8'h08);
        wait_idle0(100);
        cyc();
        check("q0_empty_rst", q0.size(), 0);

        // No checksum: 8 bytes, last on 88
        base = pops1;
        push_frame(1, 64'h1122334455667788, 8'h00);
        res1 = 64'h1122334455667788;
        capture1 = 1'b1;
        cyc();
        capture1 = 1'b0;
        res1 = '0;
        n = 0;
        while (busy1 && n < 50) begin
            n++;
            cyc();
        end
        check("busy_cycles1", n, 8);
        cyc();
        check("bytes1", pops1 - base, 8);
        check("q1_empty", q1.size(), 0);
        check("ovr1", overrun1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
